// File: rtl/issue_scoreboard_if.sv
// S1 issue-gate bundle between decode and issue_scoreboard.
// With SB_PERF_CNT_EN defined the interface also carries the two performance counters.
interface issue_scoreboard_if #(
    parameter int unsigned LANES = 2,
    parameter int unsigned NREG  = 8,
    parameter int unsigned RW    = 3
);
    logic [LANES-1:0]      valid_i;
    logic [LANES*3*RW-1:0] src_num_i;
    logic [LANES*3-1:0]    src_used_i;
    logic [LANES*RW-1:0]   dst_num_i;
    logic [LANES-1:0]      dst_wr_i;
    logic [LANES-1:0]      is_load_i;
    logic                  hold_i;
    logic                  flush_i;
    logic [LANES-1:0]      issue_o;
    logic                  fetch_next_o;
    logic [NREG-1:0]       busy_o;
`ifdef SB_PERF_CNT_EN
    logic [31:0]           perf_stall_o;
    logic [31:0]           perf_issue_o;

    modport master (
        output valid_i, src_num_i, src_used_i, dst_num_i, dst_wr_i, is_load_i, hold_i, flush_i,
        input  issue_o, fetch_next_o, busy_o, perf_stall_o, perf_issue_o
    );
    modport slave (
        input  valid_i, src_num_i, src_used_i, dst_num_i, dst_wr_i, is_load_i, hold_i, flush_i,
        output issue_o, fetch_next_o, busy_o, perf_stall_o, perf_issue_o
    );
`else
    modport master (
        output valid_i, src_num_i, src_used_i, dst_num_i, dst_wr_i, is_load_i, hold_i, flush_i,
        input  issue_o, fetch_next_o, busy_o
    );
    modport slave (
        input  valid_i, src_num_i, src_used_i, dst_num_i, dst_wr_i, is_load_i, hold_i, flush_i,
        output issue_o, fetch_next_o, busy_o
    );
`endif
endinterface

// File: rtl/issue_scoreboard.sv
// N-lane register scoreboard and in-order issue gate at S1 (decode/regread).
// Optional SB_PERF_CNT_EN adds stall/issue performance counters.
module issue_scoreboard #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned NREG     = 8,
    parameter int unsigned RW       = 3,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    issue_scoreboard_if.slave  sb
);
    localparam int unsigned CW = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

    logic [CW-1:0]    cnt_q   [NREG];
    logic [CW-1:0]    cnt_d   [NREG];
    logic [NREG-1:0]  busy;
    logic [LANES-1:0] wr_ok;
    logic [LANES-1:0] elig;
    logic [LANES-1:0] issue;
    logic [RW-1:0]    dst     [LANES];
    logic [CW-1:0]    lat_m1  [LANES];
    logic [CW-1:0]    dst_cnt [LANES];

    always_comb begin : busy_map
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // Destinations at or beyond NREG are treated as non-writing everywhere.
    always_comb begin : lane_decode
        for (int k = 0; k < LANES; k++) begin
            dst[k]     = sb.dst_num_i[k*RW +: RW];
            wr_ok[k]   = sb.valid_i[k] && sb.dst_wr_i[k] && (32'(dst[k]) < NREG);
            lat_m1[k]  = sb.is_load_i[k] ? CW'(LOAD_LAT - 1) : CW'(ALU_LAT - 1);
            dst_cnt[k] = '0;
            for (int r = 0; r < NREG; r++) begin
                if (dst[k] == RW'(r)) begin
                    dst_cnt[k] = cnt_q[r];
                end
            end
        end
    end

    always_comb begin : hazard
        logic [RW-1:0] src;
        logic          src_busy;
        src      = '0;
        src_busy = 1'b0;
        elig     = '0;
        for (int k = 0; k < LANES; k++) begin
            elig[k] = sb.valid_i[k] && !sb.hold_i && !sb.flush_i && !rst;
            for (int s = 0; s < 3; s++) begin
                src      = sb.src_num_i[k*3*RW + s*RW +: RW];
                src_busy = 1'b0;
                if (sb.src_used_i[k*3 + s]) begin
                    for (int r = 0; r < NREG; r++) begin
                        if (src == RW'(r) && busy[r]) begin
                            src_busy = 1'b1;
                        end
                    end
                    // No same-cycle forwarding from an older lane in the bundle.
                    for (int j = 0; j < LANES; j++) begin
                        if (j < k && wr_ok[j] && dst[j] == src) begin
                            src_busy = 1'b1;
                        end
                    end
                end
                if (src_busy) begin
                    elig[k] = 1'b0;
                end
            end
            if (wr_ok[k]) begin
                if (lat_m1[k] < dst_cnt[k]) begin
                    elig[k] = 1'b0;
                end
                for (int j = 0; j < LANES; j++) begin
                    if (j < k && wr_ok[j] && dst[j] == dst[k] && lat_m1[j] > lat_m1[k]) begin
                        elig[k] = 1'b0;
                    end
                end
            end
        end
    end

    // A stalled lane blocks every younger lane behind it.
    always_comb begin : prefix
        logic run;
        run   = 1'b1;
        issue = '0;
        for (int k = 0; k < LANES; k++) begin
            run      = run & elig[k];
            issue[k] = run;
        end
    end

    always_comb begin : next_cnt
        logic [CW-1:0] dec;
        logic [CW-1:0] nw;
        dec = '0;
        nw  = '0;
        for (int r = 0; r < NREG; r++) begin
            dec = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
            nw  = '0;
            for (int k = 0; k < LANES; k++) begin
                if (issue[k] && wr_ok[k] && dst[k] == RW'(r)) begin
                    nw = lat_m1[k];
                end
            end
            cnt_d[r] = (nw > dec) ? nw : dec;
            if (sb.hold_i) begin
                cnt_d[r] = cnt_q[r];
            end
            if (sb.flush_i) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign sb.issue_o      = issue;
    assign sb.fetch_next_o = (issue == sb.valid_i) && !sb.hold_i && !sb.flush_i && !rst;
    assign sb.busy_o       = busy;

`ifdef SB_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_issue_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_issue_q <= '0;
        end else begin
            if ((sb.valid_i != '0) && !sb.fetch_next_o) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            perf_issue_q <= perf_issue_q + 32'($countones(issue));
        end
    end

    assign sb.perf_stall_o = perf_stall_q;
    assign sb.perf_issue_o = perf_issue_q;
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, reset/perf sequences, and random
// stimulus checked against a ready-time reference model.
module tb_issue_scoreboard;
    localparam int ALU = 1;
    localparam int LD  = 2;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    issue_scoreboard_if #(.LANES(2), .NREG(8), .RW(3)) sb ();

    issue_scoreboard #(
        .LANES(2), .NREG(8), .RW(3), .ALU_LAT(ALU), .LOAD_LAT(LD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  valid;
        logic [17:0] src;
        logic [5:0]  used;
        logic [5:0]  dst;
        logic [1:0]  wr;
        logic [1:0]  ld;
        logic        hold;
        logic        flush;
        logic [1:0]  e_iss;
        logic        e_fetch;
        logic [7:0]  e_busy;
    } vec_t;

    vec_t vq[$];

    function automatic logic [8:0] rm(input logic [2:0] r);
        return {r, 6'd0};
    endfunction

    function automatic vec_t mk(input logic [1:0] valid, input logic [8:0] s1, input logic [8:0] s0,
                                input logic [2:0] u1, input logic [2:0] u0, input logic [2:0] d1,
                                input logic [2:0] d0, input logic [1:0] wr, input logic [1:0] ld,
                                input logic hold, input logic flush, input logic [1:0] ei,
                                input logic ef, input logic [7:0] eb);
        vec_t v;
        v.valid = valid; v.src = {s1, s0}; v.used = {u1, u0}; v.dst = {d1, d0};
        v.wr = wr; v.ld = ld; v.hold = hold; v.flush = flush;
        v.e_iss = ei; v.e_fetch = ef; v.e_busy = eb;
        return v;
    endfunction

    task automatic set_in(input logic [1:0] valid, input logic [17:0] src, input logic [5:0] used,
                          input logic [5:0] dst, input logic [1:0] wr, input logic [1:0] ld,
                          input logic hold, input logic flush);
        sb.valid_i = valid; sb.src_num_i = src; sb.src_used_i = used; sb.dst_num_i = dst;
        sb.dst_wr_i = wr; sb.is_load_i = ld; sb.hold_i = hold; sb.flush_i = flush;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(2'b11, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("rst_issue", 32'(sb.issue_o), 32'd0);
        chk("rst_fetch", 32'(sb.fetch_next_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(sb.busy_o), 32'd0);
        set_in('0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Reference model: ready_at[r] is the first cycle a consumer of r may issue.
    int         ready_at [8];
    int         now;
    logic [1:0]  r_v, r_w, r_l, e_iss;
    logic [17:0] r_s;
    logic [5:0]  r_u, r_d;
    logic        r_h, r_f, e_fetch;
    logic [7:0]  e_busy;

    task automatic model_eval();
        bit run;
        int lat [2];
        int d   [2];
        run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lat[k] = r_l[k] ? LD : ALU;
            d[k]   = int'(r_d[k*3 +: 3]);
        end
        for (int k = 0; k < 2; k++) begin
            bit el;
            el = r_v[k] && !r_h && !r_f;
            for (int s = 0; s < 3; s++) begin
                if (r_u[k*3 + s]) begin
                    int r;
                    r = int'(r_s[k*9 + s*3 +: 3]);
                    if (ready_at[r] > now) el = 1'b0;
                    for (int j = 0; j < k; j++)
                        if (r_v[j] && r_w[j] && d[j] == r) el = 1'b0;
                end
            end
            if (r_v[k] && r_w[k]) begin
                if (now + lat[k] <= ready_at[d[k]]) el = 1'b0;
                for (int j = 0; j < k; j++)
                    if (r_v[j] && r_w[j] && d[j] == d[k] && lat[j] > lat[k]) el = 1'b0;
            end
            run      = run && el;
            e_iss[k] = run;
        end
        e_fetch = (e_iss == r_v) && !r_h && !r_f;
        for (int r = 0; r < 8; r++) e_busy[r] = (ready_at[r] > now);
    endtask

    task automatic model_step();
        if (r_f) begin
            for (int r = 0; r < 8; r++) ready_at[r] = 0;
        end else if (r_h) begin
            for (int r = 0; r < 8; r++) if (ready_at[r] > now) ready_at[r]++;
        end else begin
            for (int r = 0; r < 8; r++) begin
                int nr;
                nr = -1;
                for (int k = 0; k < 2; k++)
                    if (e_iss[k] && r_w[k] && int'(r_d[k*3 +: 3]) == r)
                        nr = now + (r_l[k] ? LD : ALU);
                if (nr > ready_at[r]) ready_at[r] = nr;
            end
        end
        now++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        set_in('0, '0, '0, '0, '0, '0, 1'b0, 1'b0);

        // valid, s1, s0, u1, u0, d1, d0, wr, ld, hold, flush, e_iss, e_fetch, e_busy
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, rm(1), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 2, 2'b01, 2'b01, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, rm(2), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 8'h04));
        vq.push_back(mk(2'b01, 0, rm(2), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b11, rm(4), 0, 3'b100, 0, 0, 4, 2'b01, 2'b00, 0, 0, 2'b01, 0, 8'h00));
        vq.push_back(mk(2'b01, 0, rm(4), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 5, 2'b01, 2'b01, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b11, 0, rm(5), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 8'h20));
        vq.push_back(mk(2'b11, 0, rm(5), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 6, 2'b01, 2'b01, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, rm(6), 0, 3'b100, 0, 0, 2'b00, 2'b00, 1, 1, 2'b00, 0, 8'h40));
        vq.push_back(mk(2'b01, 0, rm(6), 0, 3'b100, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 8'h00));
        vq.push_back(mk(2'b01, 0, rm(6), 0, 3'b100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 7, 2'b01, 2'b01, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 7, 2'b01, 2'b00, 0, 0, 2'b00, 0, 8'h80));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 7, 2'b01, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b11, 0, 0, 0, 0, 3, 3, 2'b11, 2'b01, 0, 0, 2'b01, 0, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 2'b00, 0, 0, 2'b00, 0, 8'h08));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 3, 2'b01, 2'b00, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 9'd1, 0, 3'b001, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 8'h02));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0, 2'b01, 1, 8'h00));
        vq.push_back(mk(2'b01, 0, 9'd1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 1, 8'h02));
        vq.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 1, 8'h00));
        vq.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 8'h00));

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].valid, vq[i].src, vq[i].used, vq[i].dst, vq[i].wr, vq[i].ld,
                   vq[i].hold, vq[i].flush);
            @(negedge clk);
            chk($sformatf("vec%0d_issue", i), 32'(sb.issue_o), 32'(vq[i].e_iss));
            chk($sformatf("vec%0d_fetch", i), 32'(sb.fetch_next_o), 32'(vq[i].e_fetch));
            chk($sformatf("vec%0d_busy", i), 32'(sb.busy_o), 32'(vq[i].e_busy));
            @(posedge clk);
            #1;
        end

        // Reset pulse while a load to r3 is outstanding.
        do_reset();
        set_in(2'b01, '0, '0, 6'd3, 2'b01, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_load_issue", 32'(sb.issue_o), 32'd1);
        @(posedge clk);
        #1;
        set_in(2'b01, {9'd0, rm(3)}, 6'b000100, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t1_rst_issue", 32'(sb.issue_o), 32'd0);
        chk("t1_rst_fetch", 32'(sb.fetch_next_o), 32'd0);
        chk("t1_rst_busy", 32'(sb.busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t1_after_issue", 32'(sb.issue_o), 32'd1);
        chk("t1_after_fetch", 32'(sb.fetch_next_o), 32'd1);
        @(posedge clk);
        #1;

`ifdef SB_PERF_CNT_EN
        do_reset();
        set_in(2'b01, '0, '0, 6'd2, 2'b01, 2'b01, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        set_in(2'b01, {9'd0, rm(2)}, 6'b000100, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_in('0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        chk("t8_perf_stall", sb.perf_stall_o, 32'd1);
        chk("t8_perf_issue", sb.perf_issue_o, 32'd2);
`endif

        // Random stimulus against the reference model.
        do_reset();
        now = 100;
        for (int r = 0; r < 8; r++) ready_at[r] = 0;
        for (int c = 0; c < 600; c++) begin
            r_v = 2'($urandom);
            r_s = 18'($urandom);
            r_u = '0;
            for (int b = 0; b < 6; b++) r_u[b] = ($urandom_range(0, 9) < 4);
            r_d = 6'($urandom);
            r_w = '0;
            for (int k = 0; k < 2; k++) r_w[k] = ($urandom_range(0, 9) < 6);
            r_l = 2'($urandom);
            r_h = ($urandom_range(0, 9) == 0);
            r_f = ($urandom_range(0, 19) == 0);
            set_in(r_v, r_s, r_u, r_d, r_w, r_l, r_h, r_f);
            model_eval();
            @(negedge clk);
            chk($sformatf("rnd%0d_issue", c), 32'(sb.issue_o), 32'(e_iss));
            chk($sformatf("rnd%0d_fetch", c), 32'(sb.fetch_next_o), 32'(e_fetch));
            chk($sformatf("rnd%0d_busy", c), 32'(sb.busy_o), 32'(e_busy));
            @(posedge clk);
            #1;
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
